// File: rtl/cond_pkg.sv
// cond_pkg: shared constants for the WISC condition unit.
//   - Condition-code values CC_EQ..CC_NEVER; any code at or above
//     CC_RSVD_MIN is reserved and reported as an error.
//   - Bit positions of the packed status flags {V,N,C,Z}.
// Optional feature macro used by the importing modules: COND_SET_OVF_EN.
package cond_pkg;

    localparam int CC_EQ       = 0;   // Z
    localparam int CC_NE       = 1;   // !Z
    localparam int CC_LT       = 2;   // S
    localparam int CC_LE       = 3;   // S | Z
    localparam int CC_GE       = 4;   // !S
    localparam int CC_GT       = 5;   // !S & !Z
    localparam int CC_LTU      = 6;   // !C
    localparam int CC_GEU      = 7;   // C
    localparam int CC_CO       = 8;   // C
    localparam int CC_ALWAYS   = 9;
    localparam int CC_NEVER    = 10;
    localparam int CC_RSVD_MIN = 11;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    localparam int FLG_W = 4;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: purely combinational condition evaluator.
//   flags [3:0]    in   status flags {V,N,C,Z}
//   cc    [CC_W]   in   condition code
//   cond           out  condition result
//   err            out  condition code is reserved (cond forced 0)
// The signed-less-than term is N ^ V. When the overflow feature
// (COND_SET_OVF_EN) is disabled the parent drives V as 0, which
// collapses the term to the legacy MSB-only compare.
module cond_eval
    import cond_pkg::*;
#(
    parameter int CC_W = 4
) (
    input  logic [FLG_W-1:0] flags,
    input  logic [CC_W-1:0]  cc,
    output logic             cond,
    output logic             err
);

    logic s_lt;
    logic z;
    logic c;

    always_comb begin
        z    = flags[FLG_Z];
        c    = flags[FLG_C];
        s_lt = flags[FLG_N] ^ flags[FLG_V];
        cond = 1'b0;
        err  = 1'b0;
        case (int'(cc))
            CC_EQ:     cond = z;
            CC_NE:     cond = !z;
            CC_LT:     cond = s_lt;
            CC_LE:     cond = s_lt | z;
            CC_GE:     cond = !s_lt;
            CC_GT:     cond = !s_lt & !z;
            CC_LTU:    cond = !c;
            CC_GEU:    cond = c;
            CC_CO:     cond = c;
            CC_ALWAYS: cond = 1'b1;
            CC_NEVER:  cond = 1'b0;
            default:   err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: ALU flag register plus registered condition evaluation
// for set-type and branch-type instructions on the 16-bit WISC datapath.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   flag_we              capture {ovf,neg,cout,zero} into flags_q
//   zero,cout,neg,ovf    live ALU status
//   in_valid, cc         condition request and its code
//   use_live             evaluate on live ALU flags instead of flags_q
//   stall                hold output stage and flag register
//   flush                kill output stage (flag capture still allowed)
//   out_valid            set_out/taken/cc_err are valid
//   set_out [WIDTH]      zero-extended condition result
//   taken                condition true on a valid request
//   cc_err               request used a reserved condition code
//   flags_q [4]          flag register {V,N,C,Z}
// Optional feature macro: COND_SET_OVF_EN. When defined, the signed
// compare uses N ^ V. When undefined, ovf is ignored (flags_q[3] stays 0)
// and the signed compare uses N alone.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic              zero,
    input  logic              cout,
    input  logic              neg,
    input  logic              ovf,
    input  logic              in_valid,
    input  logic [CC_W-1:0]   cc,
    input  logic              use_live,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [WIDTH-1:0]  set_out,
    output logic              taken,
    output logic              cc_err,
    output logic [FLG_W-1:0]  flags_q
);

    logic             ovf_m;
    logic [FLG_W-1:0] live_flags_p0;
    logic [FLG_W-1:0] src_flags_p0;
    logic             cond_p0;
    logic             err_p0;

    logic             vld_p1;
    logic             cond_p1;
    logic             err_p1;

`ifdef COND_SET_OVF_EN
    assign ovf_m = ovf;
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
    assign ovf_m      = 1'b0;
`endif

    // Stage p0: select flag source and evaluate the condition.
    // The registered source deliberately ignores a same-cycle flag_we;
    // forwarding is only available through use_live.
    always_comb begin
        live_flags_p0 = {ovf_m, neg, cout, zero};
        src_flags_p0  = use_live ? live_flags_p0 : flags_q;
    end

    cond_eval #(
        .CC_W (CC_W)
    ) u_eval (
        .flags (src_flags_p0),
        .cc    (cc),
        .cond  (cond_p0),
        .err   (err_p0)
    );

    // Flag register: stall blocks capture, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (flag_we && !stall) begin
            flags_q <= live_flags_p0;
        end
    end

    // Stage p1: registered result. Idle cycles clear the stage so a
    // stale result is never presented as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            cond_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            cond_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else if (!stall) begin
            vld_p1  <= in_valid;
            cond_p1 <= in_valid && cond_p0;
            err_p1  <= in_valid && err_p0;
        end
    end

    assign out_valid = vld_p1;
    assign set_out   = {{(WIDTH-1){1'b0}}, cond_p1};
    assign taken     = cond_p1;
    assign cc_err    = err_p1;

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed scenarios followed by randomized traffic,
// checked against an operand-level reference model. Flags are produced
// from real 16-bit subtractions A-B, and expected conditions come from
// comparing the operands directly (A==B, signed/unsigned A<B).
module tb_cond_flag_unit;

    localparam int WIDTH = 16;
    localparam int CC_W  = 4;
`ifdef COND_SET_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flag_we;
    logic             zero;
    logic             cout;
    logic             neg;
    logic             ovf;
    logic             in_valid;
    logic [CC_W-1:0]  cc;
    logic             use_live;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] set_out;
    logic             taken;
    logic             cc_err;
    logic [3:0]       flags_q;

    always #5 clk = ~clk;

    cond_flag_unit #(
        .WIDTH (WIDTH),
        .CC_W  (CC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flag_we   (flag_we),
        .zero      (zero),
        .cout      (cout),
        .neg       (neg),
        .ovf       (ovf),
        .in_valid  (in_valid),
        .cc        (cc),
        .use_live  (use_live),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .set_out   (set_out),
        .taken     (taken),
        .cc_err    (cc_err),
        .flags_q   (flags_q)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: the flag register is represented by the operand pair
    // whose subtraction produced it. 0 - 16'h8001 gives Z=0 C=0 N=0 V=0,
    // i.e. the all-zero reset flags.
    logic [15:0] m_fa;
    logic [15:0] m_fb;
    logic        m_vld;
    logic        m_cond;
    logic        m_err;

    // {V,N,C,Z} of A-B computed as A + ~B + 1.
    function automatic logic [3:0] flags_of(input logic [15:0] a, input logic [15:0] b,
                                            input bit with_v);
        logic [16:0] d;
        logic        v;
        d = {1'b0, a} + {1'b0, ~b} + 17'd1;
        v = (a[15] != b[15]) && (d[15] != a[15]);
        return {v & with_v, d[15], d[16], (a == b)};
    endfunction

    function automatic logic cond_of(input int code, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] diff;
        logic        slt;
        logic        ult;
        logic        eq;
        diff = a - b;
        eq   = (a == b);
        ult  = (a < b);
        slt  = OVF_EN ? ($signed(a) < $signed(b)) : diff[15];
        case (code)
            0:  return eq;
            1:  return !eq;
            2:  return slt;
            3:  return slt || eq;
            4:  return !slt;
            5:  return !slt && !eq;
            6:  return ult;
            7:  return !ult;
            8:  return !ult;
            9:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model with the same inputs,
    // then compare every output 1 time unit after the edge.
    task automatic step(input logic r, input logic we, input logic [15:0] a, input logic [15:0] b,
                        input logic iv, input logic [3:0] c, input logic ul,
                        input logic st, input logic fl, input string tag);
        logic [15:0] ea;
        logic [15:0] eb;
        rst      = r;
        flag_we  = we;
        {ovf, neg, cout, zero} = flags_of(a, b, 1'b1);
        in_valid = iv;
        cc       = c;
        use_live = ul;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        if (r) begin
            m_fa = 16'h0000; m_fb = 16'h8001;
            m_vld = 1'b0; m_cond = 1'b0; m_err = 1'b0;
        end else begin
            ea = ul ? a : m_fa;
            eb = ul ? b : m_fb;
            if (fl) begin
                m_vld = 1'b0; m_cond = 1'b0; m_err = 1'b0;
            end else if (!st) begin
                m_vld  = iv;
                m_err  = iv && (int'(c) >= 11);
                m_cond = iv && (int'(c) < 11) && cond_of(int'(c), ea, eb);
            end
            if (we && !st) begin
                m_fa = a; m_fb = b;
            end
        end
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        chk({tag, ".set_out"},   32'(set_out),   32'(m_cond));
        chk({tag, ".taken"},     32'(taken),     32'(m_cond));
        chk({tag, ".cc_err"},    32'(cc_err),    32'(m_err));
        chk({tag, ".flags_q"},   32'(flags_q),   32'(flags_of(m_fa, m_fb, OVF_EN)));
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        m_fa = 16'h0000; m_fb = 16'h8001;
        m_vld = 1'b0; m_cond = 1'b0; m_err = 1'b0;

        // Reset for two cycles with busy inputs.
        step(1, 1, 16'hFFFF, 16'h1234, 1, 4'd9, 1, 0, 0, "rst0");
        step(1, 1, 16'h0005, 16'h0005, 1, 4'd0, 1, 0, 0, "rst1");
        chk("rst.flags_zero", 32'(flags_q), 32'd0);

        // Capture Z=1, then evaluate EQ from the flag register.
        step(0, 1, 16'h0007, 16'h0007, 0, 4'd0, 0, 0, 0, "eq_cap");
        step(0, 0, 16'h0001, 16'h0002, 1, 4'd0, 0, 0, 0, "eq_eval");
        chk("eq.set_out_one", 32'(set_out), 32'h0001);
        chk("eq.taken_one",   32'(taken),   32'd1);

        // Forwarding: flags_q.C=0, live cout=1, GEU.
        step(0, 1, 16'h0000, 16'h8001, 0, 4'd0, 0, 0, 0, "c0_cap");
        step(0, 0, 16'h0005, 16'h0003, 1, 4'd7, 1, 0, 0, "geu_live");
        chk("geu_live.one", 32'(set_out), 32'd1);
        step(0, 0, 16'h0005, 16'h0003, 1, 4'd7, 0, 0, 0, "geu_reg");
        chk("geu_reg.zero", 32'(set_out), 32'd0);

        // Live neg=0 ovf=1, LT: 0x8000 - 1 overflows.
        step(0, 0, 16'h8000, 16'h0001, 1, 4'd2, 1, 0, 0, "lt_ovf");
        chk("lt_ovf.result", 32'(set_out), OVF_EN ? 32'd1 : 32'd0);

        // LE request, then three stalled cycles with flag_we pulsed.
        step(0, 0, 16'h0003, 16'h0003, 1, 4'd3, 1, 0, 0, "le_req");
        step(0, 1, 16'h0001, 16'h0009, 1, 4'd10, 0, 1, 0, "stall0");
        step(0, 1, 16'hFFFF, 16'h0001, 0, 4'd1,  0, 1, 0, "stall1");
        step(0, 1, 16'h7FFF, 16'h8000, 1, 4'd13, 1, 1, 0, "stall2");
        chk("stall.out_valid_held", 32'(out_valid), 32'd1);
        step(0, 1, 16'h0004, 16'h0004, 1, 4'd0, 0, 1, 1, "flush_stall");
        chk("flush_stall.out_valid", 32'(out_valid), 32'd0);

        // Reserved code, then an idle cycle.
        step(0, 0, 16'h0002, 16'h0002, 1, 4'd12, 1, 0, 0, "rsvd");
        chk("rsvd.cc_err", 32'(cc_err), 32'd1);
        chk("rsvd.valid",  32'(out_valid), 32'd1);
        step(0, 0, 16'h0002, 16'h0002, 0, 4'd12, 1, 0, 0, "idle");
        chk("idle.cc_err", 32'(cc_err), 32'd0);

        // Reset drops an in-flight request.
        step(0, 0, 16'h0001, 16'h0001, 1, 4'd9, 0, 0, 0, "pre_rst");
        step(1, 0, 16'h0001, 16'h0001, 1, 4'd9, 0, 0, 0, "mid_rst");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            ra = pick_operand();
            rb = ($urandom_range(0, 4) == 0) ? ra : pick_operand();
            step(($urandom_range(0, 63) == 0), 1'($urandom), ra, rb,
                 ($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
